wb_regfile: RTL and testbench

//  Write-back stage plus architectural register file for the 5-stage MIPS pipeline.

---
 rtl/wb_regfile.sv | 108 ++++++++++
 tb/tb_wb_regfile.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry architectural register file for the MIPS pipeline.
// Two combinational read ports with same-cycle write-through, plus a registered commit trace and retire counter.
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            i_WB,
  input  logic [DATA_WIDTH-1:0] i_dataread,
  input  logic [DATA_WIDTH-1:0] i_alures,
  input  logic [ADDR_WIDTH-1:0] i_we,
  input  logic [ADDR_WIDTH-1:0] i_rs_addr,
  input  logic [ADDR_WIDTH-1:0] i_rt_addr,
  output logic [DATA_WIDTH-1:0] o_rs_data,
  output logic [DATA_WIDTH-1:0] o_rt_data,
  output logic [DATA_WIDTH-1:0] o_wb_data,
  output logic                  o_commit_vld,
  output logic [ADDR_WIDTH-1:0] o_commit_addr,
  output logic [DATA_WIDTH-1:0] o_commit_data,
  output logic [CNT_WIDTH-1:0]  o_retire_cnt
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  commit_vld_q, commit_vld_d;
  logic [ADDR_WIDTH-1:0] commit_addr_q, commit_addr_d;
  logic [DATA_WIDTH-1:0] commit_data_q, commit_data_d;
  logic [CNT_WIDTH-1:0]  retire_cnt_q, retire_cnt_d;

  logic [DATA_WIDTH-1:0] wb_val;
  logic                  wr_en;

  // Write-back select and write enable; a write held during reset is never visible, not even via bypass.
  always_comb begin
    wb_val = i_WB[0] ? i_dataread : i_alures;
    wr_en  = rst && i_WB[1] && (i_we != {ADDR_WIDTH{1'b0}});
  end

  assign o_wb_data = wb_val;

  // Read ports: $0 is hardwired, then the in-flight write wins over the stored value.
  always_comb begin
    if (i_rs_addr == {ADDR_WIDTH{1'b0}}) begin
      o_rs_data = {DATA_WIDTH{1'b0}};
    end else if (wr_en && (i_rs_addr == i_we)) begin
      o_rs_data = wb_val;
    end else begin
      o_rs_data = regs_q[i_rs_addr];
    end
    if (i_rt_addr == {ADDR_WIDTH{1'b0}}) begin
      o_rt_data = {DATA_WIDTH{1'b0}};
    end else if (wr_en && (i_rt_addr == i_we)) begin
      o_rt_data = wb_val;
    end else begin
      o_rt_data = regs_q[i_rt_addr];
    end
  end

  // Next-state for register file, commit trace and retire counter.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    commit_vld_d  = wr_en;
    commit_addr_d = commit_addr_q;
    commit_data_d = commit_data_q;
    retire_cnt_d  = retire_cnt_q;
    if (wr_en) begin
      regs_d[i_we]  = wb_val;
      commit_addr_d = i_we;
      commit_data_d = wb_val;
      retire_cnt_d  = retire_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      retire_cnt_d  = retire_cnt_q;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
      commit_vld_q  <= 1'b0;
      commit_addr_q <= {ADDR_WIDTH{1'b0}};
      commit_data_q <= {DATA_WIDTH{1'b0}};
      retire_cnt_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      commit_vld_q  <= commit_vld_d;
      commit_addr_q <= commit_addr_d;
      commit_data_q <= commit_data_d;
      retire_cnt_q  <= retire_cnt_d;
    end
  end

  assign o_commit_vld  = commit_vld_q;
  assign o_commit_addr = commit_addr_q;
  assign o_commit_data = commit_data_q;
  assign o_retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// compared against an array-based architectural model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  wb = 2'b00;
  logic [31:0] dr = 32'd0, ar = 32'd0;
  logic [4:0]  we = 5'd0, rs = 5'd0, rt = 5'd0;
  logic [31:0] o_rs_data, o_rt_data, o_wb_data, o_commit_data, o_retire_cnt;
  logic        o_commit_vld;
  logic [4:0]  o_commit_addr;

  int n_cmp = 0;
  int n_err = 0;

  // architectural model
  logic [31:0] mdl_regs [32];
  logic [31:0] mdl_cnt;
  logic        mdl_vld;
  logic [4:0]  mdl_addr;
  logic [31:0] mdl_data;

  wb_regfile dut (
    .clk(clk), .rst(rst), .i_WB(wb), .i_dataread(dr), .i_alures(ar), .i_we(we),
    .i_rs_addr(rs), .i_rt_addr(rt), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_wb_data(o_wb_data), .o_commit_vld(o_commit_vld), .o_commit_addr(o_commit_addr),
    .o_commit_data(o_commit_data), .o_retire_cnt(o_retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdl_wb();
    return wb[0] ? dr : ar;
  endfunction

  function automatic logic mdl_wr();
    return rst && wb[1] && (we != 5'd0);
  endfunction

  function automatic logic [31:0] mdl_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (mdl_wr() && a == we) return mdl_wb();
    return mdl_regs[a];
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
    mdl_cnt = 32'd0; mdl_vld = 1'b0; mdl_addr = 5'd0; mdl_data = 32'd0;
  endtask

  // advance one rising edge, applying the architectural effect of the current inputs
  task automatic step();
    logic        w;
    logic [31:0] v;
    w = mdl_wr();
    v = mdl_wb();
    @(posedge clk);
    if (rst) begin
      mdl_vld = w;
      if (w) begin
        mdl_regs[we] = v; mdl_addr = we; mdl_data = v; mdl_cnt = mdl_cnt + 32'd1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mdl_clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wb = 2'($urandom); dr = $urandom; ar = $urandom;
      we = 5'($urandom); rs = we; rt = 5'($urandom);
      #1;
      n_cmp++; if (o_rs_data !== 32'd0) begin n_err++; $display("FAIL reset_rs: got %h exp 0", o_rs_data); end
      n_cmp++; if (o_rt_data !== 32'd0) begin n_err++; $display("FAIL reset_rt: got %h exp 0", o_rt_data); end
      step();
      n_cmp++; if (o_commit_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b exp 0", o_commit_vld); end
      n_cmp++; if (o_retire_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d exp 0", o_retire_cnt); end
    end
    @(negedge clk);
    wb = 2'b00; rst = 1'b1;
  endtask

  task automatic test_alu_write();
    @(negedge clk);
    wb = 2'b10; we = 5'd5; ar = 32'h1234_5678; dr = 32'h0BAD_0BAD;
    step();
    wb = 2'b00; rs = 5'd5; rt = 5'd0;
    #1;
    n_cmp++; if (o_rs_data !== 32'h1234_5678) begin n_err++; $display("FAIL alu_rs: got %h exp 12345678", o_rs_data); end
    n_cmp++; if (o_commit_vld !== 1'b1) begin n_err++; $display("FAIL alu_vld: got %b exp 1", o_commit_vld); end
    n_cmp++; if (o_commit_addr !== 5'd5) begin n_err++; $display("FAIL alu_addr: got %0d exp 5", o_commit_addr); end
    n_cmp++; if (o_retire_cnt !== 32'd1) begin n_err++; $display("FAIL alu_cnt: got %0d exp 1", o_retire_cnt); end
  endtask

  task automatic test_load_bypass();
    @(negedge clk);
    wb = 2'b11; we = 5'd9; dr = 32'hDEAD_BEEF; ar = 32'h1111_2222; rs = 5'd9; rt = 5'd9;
    #1;
    n_cmp++; if (o_rs_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL byp_rs: got %h exp deadbeef", o_rs_data); end
    n_cmp++; if (o_rt_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL byp_rt: got %h exp deadbeef", o_rt_data); end
    n_cmp++; if (o_wb_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL byp_wb: got %h exp deadbeef", o_wb_data); end
    step();
    wb = 2'b00;
    #1;
    n_cmp++; if (o_rs_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_rs: got %h exp deadbeef", o_rs_data); end
    n_cmp++; if (o_commit_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_cdata: got %h exp deadbeef", o_commit_data); end
    n_cmp++; if (o_retire_cnt !== 32'd2) begin n_err++; $display("FAIL load_cnt: got %0d exp 2", o_retire_cnt); end
  endtask

  task automatic test_zero_write();
    @(negedge clk);
    wb = 2'b11; we = 5'd0; dr = 32'hFFFF_FFFF; rs = 5'd0; rt = 5'd9;
    #1;
    n_cmp++; if (o_rs_data !== 32'd0) begin n_err++; $display("FAIL zero_rs_pre: got %h exp 0", o_rs_data); end
    step();
    n_cmp++; if (o_rs_data !== 32'd0) begin n_err++; $display("FAIL zero_rs_post: got %h exp 0", o_rs_data); end
    n_cmp++; if (o_commit_vld !== 1'b0) begin n_err++; $display("FAIL zero_vld: got %b exp 0", o_commit_vld); end
    n_cmp++; if (o_retire_cnt !== 32'd2) begin n_err++; $display("FAIL zero_cnt: got %0d exp 2", o_retire_cnt); end
    n_cmp++; if (o_commit_addr !== 5'd9) begin n_err++; $display("FAIL zero_addr_hold: got %0d exp 9", o_commit_addr); end
  endtask

  task automatic test_no_regwrite();
    @(negedge clk);
    wb = 2'b10; we = 5'd7; ar = 32'h0000_1357;
    step();
    wb = 2'b01; we = 5'd7; dr = 32'hAAAA_AAAA; ar = 32'h5555_5555; rs = 5'd7; rt = 5'd7;
    #1;
    n_cmp++; if (o_wb_data !== 32'hAAAA_AAAA) begin n_err++; $display("FAIL noreg_wb: got %h exp aaaaaaaa", o_wb_data); end
    n_cmp++; if (o_rs_data !== 32'h0000_1357) begin n_err++; $display("FAIL noreg_rs_pre: got %h exp 00001357", o_rs_data); end
    step();
    wb = 2'b00;
    #1;
    n_cmp++; if (o_rt_data !== 32'h0000_1357) begin n_err++; $display("FAIL noreg_rt_post: got %h exp 00001357", o_rt_data); end
    n_cmp++; if (o_commit_vld !== 1'b0) begin n_err++; $display("FAIL noreg_vld: got %b exp 0", o_commit_vld); end
    // unknown data with no write enable must leave the file untouched
    ar = 32'hxxxx_xxxx; dr = 32'hxxxx_xxxx;
    step();
    n_cmp++; if (o_rs_data !== 32'h0000_1357) begin n_err++; $display("FAIL xhold_rs: got %h exp 00001357", o_rs_data); end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    wb = 2'b10; we = 5'd3; ar = 32'h0000_0055;
    step();
    n_cmp++; if (o_commit_addr !== 5'd3) begin n_err++; $display("FAIL mid_addr3: got %0d exp 3", o_commit_addr); end
    @(negedge clk);
    wb = 2'b10; we = 5'd4; ar = 32'h0000_0099; rs = 5'd3; rt = 5'd4;
    #2 rst = 1'b0;
    mdl_clear();
    #1;
    n_cmp++; if (o_rs_data !== 32'd0) begin n_err++; $display("FAIL mid_rs3: got %h exp 0", o_rs_data); end
    n_cmp++; if (o_rt_data !== 32'd0) begin n_err++; $display("FAIL mid_rt4: got %h exp 0", o_rt_data); end
    n_cmp++; if (o_retire_cnt !== 32'd0) begin n_err++; $display("FAIL mid_cnt: got %0d exp 0", o_retire_cnt); end
    n_cmp++; if (o_commit_vld !== 1'b0) begin n_err++; $display("FAIL mid_vld: got %b exp 0", o_commit_vld); end
    step();
    n_cmp++; if (o_rt_data !== 32'd0) begin n_err++; $display("FAIL mid_drop: got %h exp 0", o_rt_data); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (o_rt_data !== 32'h0000_0099) begin n_err++; $display("FAIL mid_byp: got %h exp 00000099", o_rt_data); end
    step();
    wb = 2'b00;
    #1;
    n_cmp++; if (o_rt_data !== 32'h0000_0099) begin n_err++; $display("FAIL mid_land: got %h exp 00000099", o_rt_data); end
    n_cmp++; if (o_retire_cnt !== 32'd1) begin n_err++; $display("FAIL mid_cnt2: got %0d exp 1", o_retire_cnt); end
    n_cmp++; if (o_rs_data !== 32'd0) begin n_err++; $display("FAIL mid_rs3_post: got %h exp 0", o_rs_data); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      wb = 2'($urandom); dr = $urandom; ar = $urandom;
      we = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? we : 5'($urandom);
      rt = ($urandom_range(0, 3) == 0) ? we : 5'($urandom);
      #1;
      n_cmp++; if (o_rs_data !== mdl_read(rs)) begin n_err++; $display("FAIL rnd_rs[%0d]: got %h exp %h", i, o_rs_data, mdl_read(rs)); end
      n_cmp++; if (o_rt_data !== mdl_read(rt)) begin n_err++; $display("FAIL rnd_rt[%0d]: got %h exp %h", i, o_rt_data, mdl_read(rt)); end
      n_cmp++; if (o_wb_data !== mdl_wb()) begin n_err++; $display("FAIL rnd_wb[%0d]: got %h exp %h", i, o_wb_data, mdl_wb()); end
      step();
      n_cmp++;
      if (o_commit_vld !== mdl_vld || o_commit_addr !== mdl_addr || o_commit_data !== mdl_data) begin
        n_err++;
        $display("FAIL rnd_commit[%0d]: got %b/%0d/%h exp %b/%0d/%h", i, o_commit_vld, o_commit_addr,
                 o_commit_data, mdl_vld, mdl_addr, mdl_data);
      end
      n_cmp++; if (o_retire_cnt !== mdl_cnt) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d exp %0d", i, o_retire_cnt, mdl_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_load_bypass();
    test_zero_write();
    test_no_regwrite();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
